// File: rtl/br_perf_pkg.sv
// +--------------------------------------------------------------------------+
// | br_perf_pkg : shared types and default constants for br_perf_monitor     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package br_perf_pkg;

  localparam int c_cnt_width_def   = 32;
  localparam int c_window_log2_def = 10;

  typedef enum logic [2:0] {
    RD_INSTR_CNT = 3'd0,
    RD_BR_CNT    = 3'd1,
    RD_MISS_CNT  = 3'd2,
    RD_MISS_PC   = 3'd3,
    RD_LAST_WIN  = 3'd4,
    RD_MAX_WIN   = 3'd5,
    RD_STATUS    = 3'd6,
    RD_RSVD      = 3'd7
  } rd_addr_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SNAP = 1'b1
  } snap_state_e;

endpackage

`default_nettype wire

// File: rtl/br_sat_counter.sv
// +--------------------------------------------------------------------------+
// | br_sat_counter : saturating event counter with synchronous clear         |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module br_sat_counter
  import br_perf_pkg::*;
#(
  parameter int WIDTH = c_cnt_width_def
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] r_cnt;

  assign sat_o = &r_cnt;
  assign cnt_o = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && !sat_o) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/br_perf_monitor.sv
// +--------------------------------------------------------------------------+
// | br_perf_monitor : branch performance counters with snapshot/readback.    |
// | Define BR_PERF_WINDOW_EN to add per-window miss statistics.              |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module br_perf_monitor
  import br_perf_pkg::*;
#(
  parameter int CNT_WIDTH   = c_cnt_width_def,
  parameter int WINDOW_LOG2 = c_window_log2_def
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        insn_vld_i,
  input  logic        br_instr_i,
  input  logic        br_miss_i,
  input  logic [31:0] br_pc_i,
  input  logic        clr_i,
  input  logic        snap_req_i,
  output logic        snap_done_o,
  input  logic        rd_en_i,
  input  logic [2:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        rd_vld_o
);

  localparam int c_win_w = WINDOW_LOG2 + 1;

  logic                 w_miss_ev;
  logic [CNT_WIDTH-1:0] w_instr_cnt, w_br_cnt, w_miss_cnt;
  logic                 w_instr_sat, w_br_sat, w_miss_sat, w_sat_any;
  logic                 r_sat;
  logic [31:0]          r_last_miss_pc;
  snap_state_e          r_state, w_state_nxt;
  logic                 w_snap_done;
  logic [CNT_WIDTH-1:0] r_sh_instr, r_sh_br, r_sh_miss;
  logic [31:0]          r_sh_pc;
  logic                 r_sh_sat;
  logic [c_win_w-1:0]   w_sh_last_win, w_sh_max_win;
  logic [31:0]          w_rd_mux;
  logic [31:0]          r_rd_data;
  logic                 r_rd_vld;

  // A miss flag only means something when a branch actually resolved.
  assign w_miss_ev = br_instr_i & br_miss_i;
  assign w_sat_any = w_instr_sat | w_br_sat | w_miss_sat;

  br_sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .inc_i(insn_vld_i),
    .cnt_o(w_instr_cnt), .sat_o(w_instr_sat)
  );

  br_sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .inc_i(br_instr_i),
    .cnt_o(w_br_cnt), .sat_o(w_br_sat)
  );

  br_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .inc_i(w_miss_ev),
    .cnt_o(w_miss_cnt), .sat_o(w_miss_sat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sat          <= 1'b0;
      r_last_miss_pc <= '0;
    end else if (clr_i) begin
      r_sat          <= 1'b0;
      r_last_miss_pc <= '0;
    end else begin
      r_sat <= r_sat | w_sat_any;
      if (w_miss_ev) begin
        r_last_miss_pc <= br_pc_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (snap_req_i) w_state_nxt = ST_SNAP;
      ST_SNAP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_snap_done = 1'b0;
    if (r_state == ST_SNAP) begin
      w_snap_done = 1'b1;
    end
  end

  assign snap_done_o = w_snap_done;

  // Shadows take the pre-edge live values, so SNAP-cycle events are excluded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh_instr <= '0;
      r_sh_br    <= '0;
      r_sh_miss  <= '0;
      r_sh_pc    <= '0;
      r_sh_sat   <= 1'b0;
    end else if (w_snap_done) begin
      r_sh_instr <= w_instr_cnt;
      r_sh_br    <= w_br_cnt;
      r_sh_miss  <= w_miss_cnt;
      r_sh_pc    <= r_last_miss_pc;
      r_sh_sat   <= r_sat | w_sat_any;
    end
  end

`ifdef BR_PERF_WINDOW_EN
  logic [WINDOW_LOG2-1:0] r_win_br;
  logic [c_win_w-1:0]     r_win_miss, r_last_win, r_max_win;
  logic [c_win_w-1:0]     r_sh_last_win, r_sh_max_win;
  logic [c_win_w-1:0]     w_win_total;
  logic                   w_win_wrap;

  assign w_win_total = r_win_miss + c_win_w'(w_miss_ev);
  assign w_win_wrap  = br_instr_i & (&r_win_br);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win_br   <= '0;
      r_win_miss <= '0;
      r_last_win <= '0;
      r_max_win  <= '0;
    end else if (clr_i) begin
      r_win_br   <= '0;
      r_win_miss <= '0;
      r_last_win <= '0;
      r_max_win  <= '0;
    end else if (br_instr_i) begin
      r_win_br <= r_win_br + WINDOW_LOG2'(1);
      if (w_win_wrap) begin
        r_last_win <= w_win_total;
        r_win_miss <= '0;
        if (w_win_total > r_max_win) begin
          r_max_win <= w_win_total;
        end
      end else begin
        r_win_miss <= w_win_total;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh_last_win <= '0;
      r_sh_max_win  <= '0;
    end else if (w_snap_done) begin
      r_sh_last_win <= r_last_win;
      r_sh_max_win  <= r_max_win;
    end
  end

  assign w_sh_last_win = r_sh_last_win;
  assign w_sh_max_win  = r_sh_max_win;
`else
  assign w_sh_last_win = '0;
  assign w_sh_max_win  = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr_i)
      RD_INSTR_CNT: w_rd_mux = 32'(r_sh_instr);
      RD_BR_CNT:    w_rd_mux = 32'(r_sh_br);
      RD_MISS_CNT:  w_rd_mux = 32'(r_sh_miss);
      RD_MISS_PC:   w_rd_mux = r_sh_pc;
      RD_LAST_WIN:  w_rd_mux = 32'(w_sh_last_win);
      RD_MAX_WIN:   w_rd_mux = 32'(w_sh_max_win);
      RD_STATUS:    w_rd_mux = {31'b0, r_sh_sat};
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= rd_en_i;
      if (rd_en_i) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_data_o = r_rd_data;
  assign rd_vld_o  = r_rd_vld;

endmodule

`default_nettype wire
